// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the leaky integrate-and-fire neuron.
// The state enums name the input-side and output-side handshake phases.
// The helpers do saturating addition and subtraction that stops at zero for
// any width up to 31 bits.
package lif_pkg;

  typedef enum logic [1:0] {
    IN_WAIT0,
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_RTZ
  } out_state_t;

  // Add a and b, clamping the result to the largest value representable in w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

  // Subtract b from a, but never go below zero.
  function automatic logic [31:0] floor_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/lif_neuron_sync_sync2.sv
// Two-flop synchronizer for a single-bit handshake line.
// Both flops reset to 0, so the line reads idle after reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lif_neuron_sync.sv
// Clocked leaky integrate-and-fire neuron.
// The neuron takes summed tokens over a 4-phase req/ack channel and adds them
// into a membrane potential. The potential leaks on a fixed period. When an
// accepted token lifts the potential to the threshold or above, the neuron
// fires and sends a spike packet on a second 4-phase channel.
// Define SYNC_IN_EN to pass in_req and out_ack through 2-flop synchronizers.
// Each handshake then takes two more cycles.
module lif_neuron_sync
  import lif_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int POT_WIDTH   = 12,
  parameter int THRESH      = 1000,
  parameter int LEAK_PERIOD = 16,
  parameter int LEAK_VAL    = 1,
  parameter int ID_WIDTH    = 6,
  parameter int NEURON_ID   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_req,
  output logic                 in_ack,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [ID_WIDTH-1:0]  out_data,
  output logic [POT_WIDTH-1:0] pot
);

  localparam int CNT_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (LEAK_PERIOD > 0) ? CNT_W'(LEAK_PERIOD - 1) : '0;
  localparam logic [31:0] THRESH_U = 32'(THRESH);
  localparam logic [31:0] LEAK_U   = 32'(LEAK_VAL);

  logic                 in_req_s;
  logic                 out_ack_s;
  in_state_t            in_state, in_next;
  out_state_t           out_state, out_next;
  logic [CNT_W-1:0]     leak_cnt;
  logic                 leak_event;
  logic                 accept;
  logic                 fire;
  logic [POT_WIDTH-1:0] pot_q, leaked, sum, pot_next;

`ifdef SYNC_IN_EN
  sync2 u_sync_req (.clk(clk), .rst(rst), .d(in_req),  .q(in_req_s));
  sync2 u_sync_ack (.clk(clk), .rst(rst), .d(out_ack), .q(out_ack_s));
`else
  assign in_req_s  = in_req;
  assign out_ack_s = out_ack;
`endif

  assign accept     = (in_state == IN_IDLE) && in_req_s && (out_state == OUT_IDLE);
  assign leak_event = (LEAK_PERIOD > 0) && (leak_cnt == CNT_MAX);
  assign in_ack     = (in_state == IN_ACK);
  assign out_req    = (out_state == OUT_REQ);
  assign out_data   = ID_WIDTH'(NEURON_ID);
  assign pot        = pot_q;

  // Free-running leak counter; a leak event fires on the wrap edge
  always_ff @(posedge clk) begin
    if (rst || (LEAK_PERIOD == 0) || leak_event) leak_cnt <= '0;
    else                                         leak_cnt <= leak_cnt + 1'b1;
  end

  // Combine leak and accept, saturate the sum, and reset the potential on a fire
  always_comb begin
    leaked = pot_q;
    if (leak_event) leaked = POT_WIDTH'(floor_sub(32'(pot_q), LEAK_U));
    sum      = POT_WIDTH'(sat_add(32'(leaked), accept ? 32'(in_data) : 32'd0, POT_WIDTH));
    fire     = accept && (32'(sum) >= THRESH_U);
    pot_next = fire ? '0 : sum;
  end

  // Membrane potential register, written only on accept or leak edges
  always_ff @(posedge clk) begin
    if (rst)                      pot_q <= '0;
    else if (accept || leak_event) pot_q <= pot_next;
  end

  // State registers for both handshake FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state  <= IN_WAIT0;
      out_state <= OUT_IDLE;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
    end
  end

  // Input FSM: drain any request in flight across reset, then do req/ack cycles
  always_comb begin
    in_next = in_state;
    case (in_state)
      IN_WAIT0: if (!in_req_s) in_next = IN_IDLE;
      IN_IDLE:  if (accept)    in_next = IN_ACK;
      IN_ACK:   if (!in_req_s) in_next = IN_IDLE;
      default:                 in_next = IN_WAIT0;
    endcase
  end

  // Output FSM: at most one spike outstanding, full return-to-zero before idle
  always_comb begin
    out_next = out_state;
    case (out_state)
      OUT_IDLE: if (fire)       out_next = OUT_REQ;
      OUT_REQ:  if (out_ack_s)  out_next = OUT_RTZ;
      OUT_RTZ:  if (!out_ack_s) out_next = OUT_IDLE;
      default:                  out_next = OUT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lif_neuron_sync.sv
// Self-checking bench for lif_neuron_sync using directed vectors.
// Three instances are used:
//   0: no leak, THRESH 1000, NEURON_ID 0x2A - reset, fire, backpressure, reset mid-op
//   1: leak every 4 cycles by 3                - leak stepping and the zero floor
//   2: no leak, THRESH 4095                    - saturation
module tb_lif_neuron_sync;

  logic       clk;
  logic       rst      [3];
  logic       in_req   [3];
  logic       in_ack   [3];
  logic [9:0] in_data  [3];
  logic       out_req  [3];
  logic       out_ack  [3];
  logic [5:0] out_data [3];
  logic [11:0] pot     [3];

  int tests_run = 0;
  int tests_failed = 0;

  lif_neuron_sync #(.LEAK_PERIOD(0), .NEURON_ID(42)) dut0 (
    .clk(clk), .rst(rst[0]), .in_req(in_req[0]), .in_ack(in_ack[0]), .in_data(in_data[0]),
    .out_req(out_req[0]), .out_ack(out_ack[0]), .out_data(out_data[0]), .pot(pot[0]));

  lif_neuron_sync #(.LEAK_PERIOD(4), .LEAK_VAL(3)) dut1 (
    .clk(clk), .rst(rst[1]), .in_req(in_req[1]), .in_ack(in_ack[1]), .in_data(in_data[1]),
    .out_req(out_req[1]), .out_ack(out_ack[1]), .out_data(out_data[1]), .pot(pot[1]));

  lif_neuron_sync #(.THRESH(4095), .LEAK_PERIOD(0)) dut2 (
    .clk(clk), .rst(rst[2]), .in_req(in_req[2]), .in_ack(in_ack[2]), .in_data(in_data[2]),
    .out_req(out_req[2]), .out_ack(out_ack[2]), .out_data(out_data[2]), .pot(pot[2]));

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Run one full token handshake on instance i and check both ack edges
  task automatic applyStimulus(input int i, input logic [9:0] d, input int exp_pot,
                               input int exp_out_req, input string tag);
    in_data[i] = d;
    in_req[i]  = 1'b1;
    tick();
    checkOutput({tag, "_ack_rise"}, int'(in_ack[i]), 1);
    checkOutput({tag, "_pot"}, int'(pot[i]), exp_pot);
    checkOutput({tag, "_out_req"}, int'(out_req[i]), exp_out_req);
    in_req[i] = 1'b0;
    tick();
    checkOutput({tag, "_ack_fall"}, int'(in_ack[i]), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; in_req[i] = 1'b0; in_data[i] = '0; out_ack[i] = 1'b0;
    end

    // Reset with in_req held high on instance 0
    in_req[0] = 1'b1;
    repeat (3) tick();
    checkOutput("rst_in_ack", int'(in_ack[0]), 0);
    checkOutput("rst_out_req", int'(out_req[0]), 0);
    checkOutput("rst_pot", int'(pot[0]), 0);
    checkOutput("rst_out_data", int'(out_data[0]), 42);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    repeat (2) tick();
    checkOutput("rst_held_req_ignored", int'(in_ack[0]), 0);
    in_req[0] = 1'b0;
    tick();
    checkOutput("rst_idle_ack", int'(in_ack[0]), 0);

    // Accumulate and fire
    applyStimulus(0, 10'd579, 579, 0, "tok579");
    applyStimulus(0, 10'd900, 0, 1, "tok900_fire");
    checkOutput("fire_out_data", int'(out_data[0]), 42);

    // Backpressure while the spike is still outstanding
    in_data[0] = 10'd5;
    in_req[0]  = 1'b1;
    repeat (2) tick();
    checkOutput("bp_ack_stalled", int'(in_ack[0]), 0);
    checkOutput("bp_pot_unchanged", int'(pot[0]), 0);
    out_ack[0] = 1'b1;
    tick();
    checkOutput("bp_out_req_drop", int'(out_req[0]), 0);
    checkOutput("bp_ack_still_stalled", int'(in_ack[0]), 0);
    out_ack[0] = 1'b0;
    tick();
    checkOutput("bp_rtz_stalled", int'(in_ack[0]), 0);
    tick();
    checkOutput("bp_accept_ack", int'(in_ack[0]), 1);
    checkOutput("bp_accept_pot", int'(pot[0]), 5);
    in_req[0] = 1'b0;
    tick();

    // Leak on instance 1: restart it so the counter phase is known
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    tick();
    in_data[1] = 10'd10;
    in_req[1]  = 1'b1;
    tick();
    checkOutput("leak_tok_ack", int'(in_ack[1]), 1);
    checkOutput("leak_tok_pot", int'(pot[1]), 10);
    in_req[1] = 1'b0;
    for (int e = 3; e <= 21; e++) begin
      int exp_p;
      tick();
      case (e)
        3:       exp_p = 10;
        4, 7:    exp_p = 7;
        8, 11:   exp_p = 4;
        12, 15:  exp_p = 1;
        16, 20:  exp_p = 0;
        default: exp_p = -1;
      endcase
      if (exp_p >= 0) checkOutput($sformatf("leak_edge%0d", e), int'(pot[1]), exp_p);
    end
    checkOutput("leak_never_fires", int'(out_req[1]), 0);

    // Saturation on instance 2
    applyStimulus(2, 10'd1023, 1023, 0, "sat1");
    applyStimulus(2, 10'd1023, 2046, 0, "sat2");
    applyStimulus(2, 10'd1023, 3069, 0, "sat3");
    applyStimulus(2, 10'd1023, 4092, 0, "sat4");
    applyStimulus(2, 10'd1023, 0, 1, "sat5_fire");
    out_ack[2] = 1'b1;
    tick();
    out_ack[2] = 1'b0;
    tick();
    applyStimulus(2, 10'd50, 50, 0, "sat_after");
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    checkOutput("sat_rst_pot", int'(pot[2]), 0);

    // Reset mid-operation on instance 0: IN_ACK with a spike outstanding
    in_data[0] = 10'd1000;
    in_req[0]  = 1'b1;
    tick();
    checkOutput("mid_ack_high", int'(in_ack[0]), 1);
    checkOutput("mid_out_req_high", int'(out_req[0]), 1);
    rst[0] = 1'b1;
    tick();
    checkOutput("mid_rst_ack", int'(in_ack[0]), 0);
    checkOutput("mid_rst_out_req", int'(out_req[0]), 0);
    checkOutput("mid_rst_pot", int'(pot[0]), 0);
    rst[0] = 1'b0;
    repeat (2) tick();
    checkOutput("mid_held_req_ignored", int'(in_ack[0]), 0);
    in_req[0] = 1'b0;
    tick();
    applyStimulus(0, 10'd7, 7, 0, "mid_new_tok");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
